// File: rtl/alu_exec_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_sequencer_pkg
// Description : State encoding and stop-cause codes for the ALU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_sequencer_pkg;

    // STOPPED keeps the 4'b1000 code already used by existing debug tooling
    typedef enum logic [3:0] {
        ST_IDLE      = 4'b0000,
        ST_FETCH     = 4'b0001,
        ST_DECODE    = 4'b0010,
        ST_EXECUTE   = 4'b0011,
        ST_WRITEBACK = 4'b0100,
        ST_STOPPED   = 4'b1000
    } seq_state_e;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_INVALID = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
    localparam logic [1:0] FAULT_HALT    = 2'b11;

    localparam int TIMEOUT_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/alu_exec_sequencer_timeout.sv
`default_nettype none
// ============================================================================
// Module      : exec_timeout_counter
// Description : EXECUTE-phase watchdog; flags the cycle in which the count
//               reaches EXEC_TIMEOUT-1.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_timeout_counter
    import alu_exec_sequencer_pkg::*;
#(
    parameter int EXEC_TIMEOUT = 64
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMEOUT_CNT_W-1:0] EXPIRE_AT = TIMEOUT_CNT_W'(EXEC_TIMEOUT - 2);

    logic [TIMEOUT_CNT_W-1:0] count_q;
    logic [TIMEOUT_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TIMEOUT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The increment on this edge is the one that reaches EXEC_TIMEOUT-1
    assign expired = enable && (count_q == EXPIRE_AT);

endmodule
`default_nettype wire

// File: rtl/alu_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_sequencer
// Description : Fetch/decode/execute/writeback controller for the ALU path.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_sequencer
    import alu_exec_sequencer_pkg::*;
#(
    parameter int PC_WIDTH     = 16,
    parameter int EXEC_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [PC_WIDTH-1:0] start_pc,
    input  logic                halt_req,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instruction,
    input  logic                invalid_instruction,
    input  logic [1:0]          dec_alu_write,
    output logic                alu_start,
    input  logic                alu_done,
    output logic [1:0]          alu_write,
    output logic [PC_WIDTH-1:0] pc,
    output logic                busy,
    output logic                stopped,
    output logic [1:0]          fault,
    output logic [31:0]         retired
);

    seq_state_e          state_q,     state_d;
    logic [PC_WIDTH-1:0] pc_q,        pc_d;
    logic [31:0]         instr_q,     instr_d;
    logic [1:0]          fault_q,     fault_d;
    logic [31:0]         retired_q,   retired_d;
    logic [1:0]          wpat_q,      wpat_d;
    logic                imem_req_q,  imem_req_d;
    logic [1:0]          alu_write_q, alu_write_d;

    logic alu_start_w;
    logic cnt_clear;
    logic cnt_enable;
    logic cnt_expired;

    exec_timeout_counter #(
        .EXEC_TIMEOUT (EXEC_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        fault_d     = fault_q;
        retired_d   = retired_q;
        wpat_d      = wpat_q;
        imem_req_d  = imem_req_q;
        alu_write_d = 2'b00;
        alu_start_w = 1'b0;
        cnt_clear   = 1'b0;
        cnt_enable  = 1'b0;

        case (state_q)
            ST_IDLE, ST_STOPPED: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    pc_d       = start_pc;
                    fault_d    = FAULT_NONE;
                    imem_req_d = 1'b1;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    imem_req_d = 1'b0;
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Decoder verdict is combinational on instr_q, so the launch
                // pulse cannot be registered ahead of this cycle.
                if (invalid_instruction) begin
                    fault_d = FAULT_INVALID;
                    state_d = ST_STOPPED;
                end else begin
                    alu_start_w = 1'b1;
                    wpat_d      = dec_alu_write;
                    cnt_clear   = 1'b1;
                    state_d     = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                cnt_enable = 1'b1;
                if (alu_done) begin
                    alu_write_d = wpat_q;
                    state_d     = ST_WRITEBACK;
                end else if (cnt_expired) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = ST_STOPPED;
                end
            end
            ST_WRITEBACK: begin
                pc_d      = pc_q + PC_WIDTH'(1);
                retired_d = retired_q + 32'd1;
                if (halt_req) begin
                    fault_d = FAULT_HALT;
                    state_d = ST_STOPPED;
                end else begin
                    imem_req_d = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            instr_q     <= '0;
            fault_q     <= FAULT_NONE;
            retired_q   <= '0;
            wpat_q      <= 2'b00;
            imem_req_q  <= 1'b0;
            alu_write_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            fault_q     <= fault_d;
            retired_q   <= retired_d;
            wpat_q      <= wpat_d;
            imem_req_q  <= imem_req_d;
            alu_write_q <= alu_write_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign alu_start   = alu_start_w;
    assign alu_write   = alu_write_q;
    assign pc          = pc_q;
    assign fault       = fault_q;
    assign retired     = retired_q;
    assign stopped     = (state_q == ST_STOPPED);
    assign busy        = (state_q == ST_FETCH)   || (state_q == ST_DECODE) ||
                         (state_q == ST_EXECUTE) || (state_q == ST_WRITEBACK);

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_sequencer
// Description : Randomized self-checking bench with an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_sequencer;

    localparam int PCW = 16;
    localparam int TO  = 8;
    localparam int NI  = 40;

    logic            clk = 1'b0;
    logic            resetn;
    logic            start;
    logic [PCW-1:0]  start_pc;
    logic            halt_req;
    logic            imem_req;
    logic [PCW-1:0]  imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic [31:0]     instruction;
    logic            invalid_instruction;
    logic [1:0]      dec_alu_write;
    logic            alu_start;
    logic            alu_done;
    logic [1:0]      alu_write;
    logic [PCW-1:0]  pc;
    logic            busy;
    logic            stopped;
    logic [1:0]      fault;
    logic [31:0]     retired;

    alu_exec_sequencer #(
        .PC_WIDTH     (PCW),
        .EXEC_TIMEOUT (TO)
    ) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .start               (start),
        .start_pc            (start_pc),
        .halt_req            (halt_req),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_ack            (imem_ack),
        .imem_rdata          (imem_rdata),
        .instruction         (instruction),
        .invalid_instruction (invalid_instruction),
        .dec_alu_write       (dec_alu_write),
        .alu_start           (alu_start),
        .alu_done            (alu_done),
        .alu_write           (alu_write),
        .pc                  (pc),
        .busy                (busy),
        .stopped             (stopped),
        .fault               (fault),
        .retired             (retired)
    );

    // Decoder stub: top nibble F marks an illegal opcode, low bits are the write pattern
    assign invalid_instruction = (instruction[31:28] == 4'hF);
    assign dec_alu_write       = instruction[1:0];

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [PCW-1:0] m_pc;
    logic [31:0]    m_ret;
    logic [1:0]     m_fault;
    logic [31:0]    m_instr;
    bit             m_stop;
    int             rc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic ack, input logic [31:0] rd, input logic done,
                       input logic hlt, input logic st, input logic [PCW-1:0] spc);
        @(negedge clk);
        imem_ack   = ack;
        imem_rdata = rd;
        alu_done   = done;
        halt_req   = hlt;
        start      = st;
        start_pc   = spc;
        #1;
    endtask

    task automatic stop_and_restart();
        logic [PCW-1:0] spc;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        chk("stop_flag",   {63'b0, stopped},   64'd1);
        chk("stop_busy",   {63'b0, busy},      64'd0);
        chk("stop_fault",  {62'b0, fault},     {62'b0, m_fault});
        chk("stop_pc",     {48'b0, pc},        {48'b0, m_pc});
        chk("stop_ret",    {32'b0, retired},   {32'b0, m_ret});
        chk("stop_instr",  {32'b0, instruction}, {32'b0, m_instr});
        chk("stop_req",    {63'b0, imem_req},  64'd0);
        chk("stop_awr",    {62'b0, alu_write}, 64'd0);
        chk("stop_ast",    {63'b0, alu_start}, 64'd0);
        if (rc == 0)      spc = 16'hFFFF;
        else if (rc == 1) spc = 16'h0100;
        else              spc = PCW'($urandom);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, spc);
        chk("stop_hold",   {63'b0, stopped},   64'd1);
        m_pc    = spc;
        m_fault = 2'b00;
        m_stop  = 1'b0;
        rc++;
    endtask

    initial begin
        int             ack_lat;
        int             lat;
        bit             inv;
        bit             hlt;
        bit             done_seen;
        logic [31:0]    word;
        logic [1:0]     pat;

        resetn = 1'b0; start = 1'b0; start_pc = '0; halt_req = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; alu_done = 1'b0;
        m_pc = '0; m_ret = '0; m_fault = 2'b00; m_instr = '0; m_stop = 1'b0; rc = 0;

        #12;
        chk("rst_req",   {63'b0, imem_req},  64'd0);
        chk("rst_pc",    {48'b0, pc},        64'd0);
        chk("rst_instr", {32'b0, instruction}, 64'd0);
        chk("rst_fault", {62'b0, fault},     64'd0);
        chk("rst_ret",   {32'b0, retired},   64'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
            chk("idle_busy", {62'b0, busy, stopped}, 64'd0);
            chk("idle_req",  {63'b0, imem_req},      64'd0);
        end

        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'h0010);
        m_pc = 16'h0010;

        for (int i = 0; i < NI; i++) begin
            if (m_stop) stop_and_restart();

            ack_lat = $urandom_range(0, 3);
            inv     = ($urandom_range(0, 9) == 0);
            lat     = ($urandom_range(0, 5) == 0) ? 99 : $urandom_range(1, TO - 1);
            hlt     = ($urandom_range(0, 7) == 0);
            case (i)
                0: begin ack_lat = 0; inv = 1'b0; lat = 1;  hlt = 1'b0; end
                1: begin inv = 1'b1; end
                2: begin inv = 1'b0; lat = 2;  hlt = 1'b0; end
                3: begin inv = 1'b0; lat = TO - 1; hlt = 1'b1; end
                4: begin inv = 1'b0; lat = 99; end
                default: ;
            endcase
            word = $urandom;
            word[31:28] = inv ? 4'hF : {1'b0, word[30:28]};
            if (i == 0) word[1:0] = 2'b01;
            pat = word[1:0];

            for (int j = 0; j <= ack_lat; j++) begin
                cyc(j == ack_lat, word, 1'b0, 1'b0, 1'($urandom), PCW'($urandom));
                chk("f_req",  {63'b0, imem_req},  64'd1);
                chk("f_addr", {48'b0, imem_addr}, {48'b0, m_pc});
                chk("f_busy", {62'b0, busy, stopped}, 64'd2);
                if (j == 0) begin
                    chk("f_pc",    {48'b0, pc},      {48'b0, m_pc});
                    chk("f_ret",   {32'b0, retired}, {32'b0, m_ret});
                    chk("f_fault", {62'b0, fault},   64'd0);
                end
            end

            cyc(1'b0, 32'h0, 1'b0, hlt, 1'($urandom), PCW'($urandom));
            m_instr = word;
            chk("d_instr", {32'b0, instruction}, {32'b0, word});
            chk("d_req",   {63'b0, imem_req},    64'd0);
            chk("d_ast",   {63'b0, alu_start},   {63'b0, !inv});
            chk("d_awr",   {62'b0, alu_write},   64'd0);
            if (inv) begin
                m_fault = 2'b01;
                m_stop  = 1'b1;
                continue;
            end

            done_seen = 1'b0;
            for (int k = 1; k <= TO - 1; k++) begin
                cyc(1'b0, 32'h0, k == lat, hlt, 1'($urandom), PCW'($urandom));
                chk("e_ast",  {63'b0, alu_start}, 64'd0);
                chk("e_awr",  {62'b0, alu_write}, 64'd0);
                chk("e_busy", {62'b0, busy, stopped}, 64'd2);
                if (k == lat) begin
                    done_seen = 1'b1;
                    break;
                end
            end
            if (!done_seen) begin
                m_fault = 2'b10;
                m_stop  = 1'b1;
                continue;
            end

            cyc(1'b0, 32'h0, 1'b0, hlt, 1'($urandom), PCW'($urandom));
            chk("w_awr", {62'b0, alu_write}, {62'b0, pat});
            chk("w_ast", {63'b0, alu_start}, 64'd0);
            chk("w_pc",  {48'b0, pc},        {48'b0, m_pc});
            m_pc  = m_pc + 1'b1;
            m_ret = m_ret + 1;
            if (hlt) begin
                m_fault = 2'b11;
                m_stop  = 1'b1;
            end
        end

        if (m_stop) stop_and_restart();
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        chk("rf_req0", {63'b0, imem_req}, 64'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        chk("rf_req1", {63'b0, imem_req}, 64'd1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("ar_req",   {63'b0, imem_req},    64'd0);
        chk("ar_pc",    {48'b0, pc},          64'd0);
        chk("ar_instr", {32'b0, instruction}, 64'd0);
        chk("ar_ret",   {32'b0, retired},     64'd0);
        chk("ar_stat",  {60'b0, busy, stopped, fault}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(i == 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, '0);
            chk("ar_idle", {61'b0, busy, stopped, imem_req}, 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
